// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the SIMPLE-RISC controller slice.
// The HALT state exists only when ILLEGAL_TRAP_EN is defined.
package cpu_ctrl_pkg;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    localparam logic [1:0] OPX_MOV_REG = 2'b00;
    localparam logic [1:0] OPX_MOV_IMM = 2'b10;
    localparam logic [1:0] OPX_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
`ifdef ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Wrapper-to-controller bundle: start/load/instruction in, regfile and datapath controls out.
interface cpu_ctrl_fsm_if #(parameter int DATA_W = 16);

    logic              s;
    logic              load;
    logic [DATA_W-1:0] in;
    logic              w;
    logic              write;
    logic [2:0]        writenum;
    logic [2:0]        readnum;
    logic [1:0]        vsel;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic [DATA_W-1:0] sximm8;
    logic [DATA_W-1:0] sximm5;
    logic              illegal;

    modport master (
        output s, load, in,
        input  w, write, writenum, readnum, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm8, sximm5, illegal
    );

    modport slave (
        input  s, load, in,
        output w, write, writenum, readnum, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, sximm8, sximm5, illegal
    );

endinterface

// File: rtl/cpu_instr_dec.sv
// Combinational IR field extraction, immediate sign extension and instruction class flags.
module cpu_instr_dec
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [2:0]        rm,
    output logic [1:0]        sh,
    output logic [1:0]        op,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic              is_mov_imm,
    output logic              is_mov_reg,
    output logic              is_mvn,
    output logic              is_cmp,
    output logic              is_alu_ab
);

    logic        [2:0]        opcode;
    logic signed [DATA_W-1:0] imm8_s;
    logic signed [DATA_W-1:0] imm5_s;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign imm8_s = DATA_W'($signed(ir[7:0]));
    assign imm5_s = DATA_W'($signed(ir[4:0]));
    assign sximm8 = imm8_s;
    assign sximm5 = imm5_s;

    assign is_mov_imm = (opcode == OP_MOV) && (op == OPX_MOV_IMM);
    assign is_mov_reg = (opcode == OP_MOV) && (op == OPX_MOV_REG);
    assign is_mvn     = (opcode == OP_ALU) && (op == OPX_MVN);
    assign is_cmp     = (opcode == OP_ALU) && (op == ALU_SUB);
    // ADD, CMP and AND read both operands, so they start at GET_A.
    assign is_alu_ab  = (opcode == OP_ALU) && (op != OPX_MVN);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle SIMPLE-RISC controller with registered Moore outputs.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes in HALT instead of returning to WAIT.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input logic           clk,
    input logic           reset,
    cpu_ctrl_fsm_if.slave bus
);

    state_t            state;
    logic [DATA_W-1:0] ir;

    logic [2:0] rn, rd, rm;
    logic [1:0] sh, op;
    logic       is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_alu_ab;

    cpu_instr_dec #(.DATA_W(DATA_W)) u_dec (
        .ir         (ir),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .op         (op),
        .sximm8     (bus.sximm8),
        .sximm5     (bus.sximm5),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_mvn     (is_mvn),
        .is_cmp     (is_cmp),
        .is_alu_ab  (is_alu_ab)
    );

`ifndef ILLEGAL_TRAP_EN
    assign bus.illegal = 1'b0;
`endif

    // Outputs are registered alongside the state they belong to, so each
    // branch sets the controls for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_WAIT;
            ir           <= '0;
            bus.w        <= 1'b1;
            bus.write    <= 1'b0;
            bus.writenum <= 3'd0;
            bus.readnum  <= 3'd0;
            bus.vsel     <= VSEL_C;
            bus.loada    <= 1'b0;
            bus.loadb    <= 1'b0;
            bus.loadc    <= 1'b0;
            bus.loads    <= 1'b0;
            bus.asel     <= 1'b0;
            bus.bsel     <= 1'b0;
            bus.shift    <= 2'b00;
            bus.ALUop    <= ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
            bus.illegal  <= 1'b0;
`endif
        end else begin
            bus.w        <= 1'b0;
            bus.write    <= 1'b0;
            bus.writenum <= 3'd0;
            bus.readnum  <= 3'd0;
            bus.vsel     <= VSEL_C;
            bus.loada    <= 1'b0;
            bus.loadb    <= 1'b0;
            bus.loadc    <= 1'b0;
            bus.loads    <= 1'b0;
            bus.asel     <= 1'b0;
            bus.bsel     <= 1'b0;
            bus.shift    <= 2'b00;
            bus.ALUop    <= ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
            bus.illegal  <= 1'b0;
`endif
            case (state)
                S_WAIT: begin
                    if (bus.load) ir <= bus.in;
                    if (bus.s) begin
                        state <= S_DECODE;
                    end else begin
                        state <= S_WAIT;
                        bus.w <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (is_mov_imm) begin
                        state        <= S_WRITE_IMM;
                        bus.writenum <= rn;
                        bus.vsel     <= VSEL_IMM;
                        bus.write    <= 1'b1;
                    end else if (is_mov_reg || is_mvn) begin
                        state       <= S_GET_B;
                        bus.readnum <= rm;
                        bus.loadb   <= 1'b1;
                    end else if (is_alu_ab) begin
                        state       <= S_GET_A;
                        bus.readnum <= rn;
                        bus.loada   <= 1'b1;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state       <= S_HALT;
                        bus.illegal <= 1'b1;
`else
                        state       <= S_WAIT;
                        bus.w       <= 1'b1;
`endif
                    end
                end
                S_GET_A: begin
                    state       <= S_GET_B;
                    bus.readnum <= rm;
                    bus.loadb   <= 1'b1;
                end
                S_GET_B: begin
                    state     <= S_ALU;
                    bus.shift <= sh;
                    bus.asel  <= is_mov_reg || is_mvn;
                    bus.ALUop <= is_mov_reg ? ALU_ADD : op;
                    if (is_cmp) bus.loads <= 1'b1;
                    else        bus.loadc <= 1'b1;
                end
                S_ALU: begin
                    if (is_cmp) begin
                        state <= S_WAIT;
                        bus.w <= 1'b1;
                    end else begin
                        state        <= S_WRITE_REG;
                        bus.writenum <= rd;
                        bus.vsel     <= VSEL_C;
                        bus.write    <= 1'b1;
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                S_HALT: begin
                    state       <= S_HALT;
                    bus.illegal <= 1'b1;
                end
`endif
                default: begin
                    state <= S_WAIT;
                    bus.w <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle controller that sequences the 8x16 register file plus the A/B/C/status datapath through one SIMPLE-RISC instruction at a time. It holds an instruction register (IR), decodes it, and drives the regfile controls: writenum, readnum and write. It also drives the datapath controls: load enables, operand selects, shift, ALUop and sign-extended immediates. It sits between the top-level CPU wrapper and the datapath; `w` reports idle to the wrapper.

Parameters:
DATA_W, 16, datapath/instruction width; sximm8/sximm5 are sign-extended to this width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
s  in  1  start; sampled only in WAIT
load  in  1  IR load enable; honoured only in WAIT
in  in  DATA_W  instruction word
w  out  1  idle (FSM in WAIT)
write  out  1  regfile write enable
writenum  out  3  regfile write address
readnum  out  3  regfile read address
vsel  out  2  writeback source: 00=C, 10=sximm8 (01/11 never driven)
loada, loadb, loadc, loads  out  1 each  register enables for A, B, C and status
asel, bsel  out  1 each  asel=1 forces A operand to 0; bsel=1 selects sximm5
shift  out  2  shifter op
ALUop  out  2  00 ADD, 01 SUB/CMP, 10 AND, 11 NOT-B
sximm8, sximm5  out  DATA_W  sign-extended IR[7:0] and IR[4:0]
illegal  out  1  illegal-opcode indicator

Behaviour:
- Interface: one clock `clk`. `reset` is asynchronous and active-high; it forces state=WAIT and IR=0.
- Output scheme: all outputs are Moore functions of state and IR. In WAIT and during reset, all enables are 0, w=1 and illegal=0.
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Unused controls: outside the states listed below, every enable is 0, shift=00 and ALUop=00.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, HALT (HALT exists only with the macro).
- WAIT: if load, IR<=in. If s, next state is DECODE; otherwise stay in WAIT.
- Simultaneous s and load in WAIT: DECODE uses the newly loaded IR.
- DECODE dispatch:
  - 110/10 (MOV imm) -> WRITE_IMM.
  - 110/00 (MOV reg) and 101/11 (MVN) -> GET_B.
  - 101/00 (ADD), 101/01 (CMP) and 101/10 (AND) -> GET_A.
  - Anything else is illegal (see Optional Feature).
- WRITE_IMM: writenum=Rn, vsel=10, write=1; next state WAIT. MOV imm takes 3 cycles from s to w=1.
- GET_A: readnum=Rn, loada=1; next state GET_B.
- GET_B: readnum=Rm, loadb=1; next state ALU.
- ALU: shift=sh, bsel=0.
  - asel=1 for MOV reg and MVN; asel=0 otherwise.
  - ALUop=op for opcode 101; ALUop=00 for MOV reg.
  - CMP: loads=1, loadc=0, next state WAIT.
  - All other instructions: loadc=1, next state WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=00, write=1; next state WAIT.
- Latency (cycles until w returns to 1): MOV reg/MVN 5, ADD/AND 6, CMP 5.
- write is never asserted in the same cycle as loada or loadb.
- s while busy is ignored. If s is still high on return to WAIT, the next instruction starts (level-sensitive).
- load while busy is ignored; IR is stable for the whole instruction.
- Reset mid-instruction: next observed state is WAIT with all enables 0. No partial write is retried.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: an illegal decode goes to HALT. HALT drives illegal=1, w=0 and all enables 0, and exits only via reset.
- Undefined: an illegal decode returns to WAIT with no enables asserted, and illegal is tied to 0.

Decomposition:
- Package cpu_ctrl_pkg: state enum; opcode and op constants (OP_MOV=3'b110, OP_ALU=3'b101); vsel encodings; ALUop encodings.
- Sub-module cpu_instr_dec: combinational IR field extraction, sign extension of sximm8/sximm5, and legal/class flags.

Test Plan:
- MOV immediate: load in=16'hD007 with s -> WRITE_IMM cycle shows write=1, writenum=0, vsel=10, sximm8=16'h0007; w=1 on cycle 3.
- Negative immediate: in=16'hD1FE -> sximm8=16'hFFFE, writenum=1.
- ADD: in=16'hA148 -> readnum=1 with loada, then readnum=0 with loadb, then shift=01, ALUop=00, loadc=1, then write=1, writenum=2, vsel=00; w=1 after 6 cycles.
- CMP: in=16'hA900 -> ALU cycle shows loads=1, loadc=0, ALUop=01; write is never asserted.
- Illegal and busy inputs: in=16'h0000 -> with macro, illegal=1 and w=0 held until reset; without macro, back in WAIT with no writes. Also load=1, in=16'hD0FF during an ADD -> IR is unchanged.
- Reset mid-instruction: assert reset in GET_B of an ADD -> immediately w=1, all enables 0, IR=0.
